mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store unit between the MEM-stage pipeline register and the word-only data memory (256x32, byte window 0x400-0x7FF, combinational read, write on posedge clk).
- Accepts one byte, halfword or word load/store per request and checks alignment and range.
- Stores narrower than a word become a read-modify-write. Loads are byte-extracted and sign- or zero-extended.
- Returns a one-cycle response pulse with load data or an exception flag; stalls upstream while busy.

Parameters:
BASE_ADDR  32'h400  first byte address of data memory
MEM_BYTES  1024     memory size in bytes; legal addresses are BASE_ADDR .. BASE_ADDR+MEM_BYTES-1

Ports:
clk        in   1   clock, all state on rising edge
reset      in   1   asynchronous, active-low reset
req_valid  in   1   request present
req_ready  out  1   unit can accept; a request is accepted when req_valid & req_ready at the clock edge
req_we     in   1   1 = store, 0 = load
req_size   in   2   0 = byte, 1 = half, 2 = word, 3 = illegal
req_signed in   1   sign-extend load result (byte/half only)
req_addr   in   32  byte address
req_wdata  in   32  store data, right-justified
resp_valid out  1   one-cycle completion pulse
resp_rdata out  32  extended load data; 0 for stores and exceptions
resp_exc   out  1   misaligned, out-of-range or illegal size; valid with resp_valid
MemRead    out  1   to data memory
MemWrite   out  1   to data memory
dm_addr    out  32  word-aligned address to data memory
dm_wdata   out  32  write data to data memory
dm_rdata   in   32  read data from data memory (combinational)

Behaviour:
- Reset (active-low, asynchronous):
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_exc=0; all request/merge registers=0.
  - MemRead, MemWrite, dm_addr, dm_wdata are decoded from state, so they drop to 0 immediately.
  - Reset during ACCESS/WRITE aborts the operation with no memory write and no response.
- States:
  - IDLE: req_ready=1, strobes 0.
  - ACCESS: req_ready=0.
  - WRITE: req_ready=0.
- Acceptance in IDLE (edge N): latch we, size, signed, addr, wdata.
  - Exception check, combinational on the request. Any one condition raises an exception:
    - size==3
    - half with addr[0]=1
    - word with addr[1:0]!=0
    - addr<BASE_ADDR
    - addr>BASE_ADDR+MEM_BYTES-1
  - On exception: stay in IDLE; resp_valid=1, resp_exc=1, resp_rdata=0 during cycle N+1; no memory strobe ever asserted.
  - Otherwise: go to ACCESS for cycle N+1.
- ACCESS:
  - dm_addr = {addr[31:2],2'b00}.
  - Load:
    - MemRead=1.
    - Byte lane from addr[1:0], half lane from addr[1], little-endian (byte0 = bits 7:0).
    - Extend by signed; register into resp_rdata.
    - Go to IDLE; resp_valid=1 in cycle N+2.
  - Word store:
    - MemWrite=1, dm_wdata=wdata.
    - Go to IDLE; resp_valid=1, resp_rdata=0 in N+2.
  - Byte/half store:
    - MemRead=1.
    - Merge register = dm_rdata with the selected lane replaced by wdata[7:0] or wdata[15:0].
    - Go to WRITE.
- WRITE:
  - MemWrite=1, dm_addr held, dm_wdata=merge register.
  - Go to IDLE; resp_valid=1 in N+3.
- resp_valid is exactly one cycle per accepted request. A new request may be accepted in the same cycle resp_valid is high, because the state is already IDLE.
- MemRead and MemWrite are never high together. Outside ACCESS/WRITE, dm_addr=0 and dm_wdata=0.
- Latencies, accept edge to response: load 2, word store 2, sub-word store 3, exception 1.
- req_* inputs are ignored while req_ready=0. Latched values are used throughout the operation.

Test Plan:
- Word store 0x400 <- 0xDEADBEEF, then word load 0x400 -> MemWrite pulse in ACCESS; load resp_valid 2 cycles after accept with rdata=0xDEADBEEF, exc=0.
- Signed byte load 0x403 of 0xDEADBEEF -> 0xFFFFFFDE. Unsigned half load 0x400 -> 0x0000BEEF. Signed half load 0x402 -> 0xFFFFDEAD.
- Byte store 0x401 <- 0x12 over 0xDEADBEEF -> READ cycle then WRITE cycle with dm_wdata=0xDEAD12EF; response 3 cycles after accept; word load 0x400 returns 0xDEAD12EF.
- Half load 0x401, word store 0x402, load 0x3FC, load 0x800, size=3 -> each gives resp_exc=1 one cycle after accept, rdata=0, MemRead/MemWrite never asserted.
- Back-to-back: req_valid held high with 3 loads -> accepted every 2 cycles; req_ready low in ACCESS; responses in order, one pulse each.
- Assert reset low in WRITE of a half store to 0x404 -> strobes drop immediately, no resp_valid, word at 0x404 unchanged; after release req_ready=1.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-wide data memory with sub-word read-modify-write.
// Latency accept->resp: load 2, word store 2, sub-word store 3, exception 1.
// Backpressure: req_ready is low while an access is in flight.
module mem_access_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h400,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(MEM_BYTES) - 32'd1;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE} state_t;

    state_t      state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] merge;

    logic        req_exc;
    logic        word_st;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] merge_data;

    always_comb begin
        req_exc = 1'b0;
        case (req_size)
            2'd1:    req_exc = req_addr[0];
            2'd2:    req_exc = (req_addr[1:0] != 2'd0);
            2'd3:    req_exc = 1'b1;
            default: req_exc = 1'b0;
        endcase
        if (req_addr < BASE_ADDR || req_addr > LAST_ADDR)
            req_exc = 1'b1;
    end

    // Little-endian lane select from the latched address.
    always_comb begin
        ld_byte = dm_rdata[{r_addr[1:0], 3'b000} +: 8];
        ld_half = r_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (r_size)
            2'd0:    ld_data = {{24{r_signed & ld_byte[7]}}, ld_byte};
            2'd1:    ld_data = {{16{r_signed & ld_half[15]}}, ld_half};
            default: ld_data = dm_rdata;
        endcase
    end

    always_comb begin
        merge_data = dm_rdata;
        if (r_size == 2'd0)
            merge_data[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else
            merge_data[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end

    assign word_st   = r_we && (r_size == 2'd2);
    assign req_ready = (state == IDLE);
    assign MemRead   = (state == ACCESS) && !word_st;
    assign MemWrite  = ((state == ACCESS) && word_st) || (state == WRITE);
    assign dm_addr   = (state == IDLE) ? 32'd0 : {r_addr[31:2], 2'b00};
    assign dm_wdata  = ((state == ACCESS) && word_st) ? r_wdata :
                       (state == WRITE)               ? merge   : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_signed   <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            merge      <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_exc   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_exc   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        if (req_exc) begin
                            resp_valid <= 1'b1;
                            resp_exc   <= 1'b1;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!r_we) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= ld_data;
                        state      <= IDLE;
                    end else if (word_st) begin
                        resp_valid <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        merge <= merge_data;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
